// File: rtl/pipe_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : pipe_ctrl                                                     |
// | Purpose  : Stall/flush scheduler for the 5-stage core. Drives the        |
// |            pipeline-register hold/flush controls and the PC redirect      |
// |            port, and sequences interrupt entry (drain, redirect, bubble). |
// | Options  : PIPE_CTRL_MEM_TIMEOUT_EN - adds a memory-wait timeout counter |
// |            that pulses bus_err_o; otherwise bus_err_o is tied low.       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module pipe_ctrl #(
   parameter int DATA_WIDTH   = 32,
   parameter int DRAIN_CYCLES = 2,
   parameter int MEM_TIMEOUT  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  mem_busy_i,
   input  logic                  br_taken_i,
   input  logic [DATA_WIDTH-1:0] br_target_i,
   input  logic                  ld_use_i,
   input  logic                  irq_i,
   input  logic [DATA_WIDTH-1:0] irq_vec_i,
   input  logic [DATA_WIDTH-1:0] id_pc_i,
   output logic                  hold_pc_o,
   output logic                  hold_if_id_o,
   output logic                  flush_if_id_o,
   output logic                  flush_id_ex_o,
   output logic                  hold_id_ex_o,
   output logic                  hold_ex_mem_o,
   output logic                  pc_set_o,
   output logic [DATA_WIDTH-1:0] pc_set_val_o,
   output logic [DATA_WIDTH-1:0] epc_o,
   output logic                  irq_ack_o,
   output logic                  bus_err_o
);

   localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

   // The drain counter is loaded with DRAIN_CYCLES-1 and the jump happens
   // after the cycle in which it reads zero, giving DRAIN_CYCLES bubbles.
   localparam logic [DRAIN_W-1:0] c_drain_load = DRAIN_W'(DRAIN_CYCLES - 1);

   localparam logic [1:0] c_st_run       = 2'd0;
   localparam logic [1:0] c_st_redirect  = 2'd1;
   localparam logic [1:0] c_st_irq_drain = 2'd2;
   localparam logic [1:0] c_st_irq_jump  = 2'd3;

   // A zero-length drain would let the redirect overtake EX/MEM instructions.
   if (DRAIN_CYCLES < 1 || MEM_TIMEOUT < 1) begin : g_bad_param
      $error("pipe_ctrl: DRAIN_CYCLES and MEM_TIMEOUT must be at least 1");
   end

   logic [1:0]            r_state;
   logic [DRAIN_W-1:0]    r_drain_cnt;
   logic [DATA_WIDTH-1:0] r_epc;
   logic [1:0]            w_next_state;
   logic [DRAIN_W-1:0]    w_next_drain;
   logic                  w_epc_load;

   assign epc_o = r_epc;

   // Decode controls and next state; mem_busy_i freezes everything and wins.
   always_comb begin
      hold_pc_o     = 1'b0;
      hold_if_id_o  = 1'b0;
      flush_if_id_o = 1'b0;
      flush_id_ex_o = 1'b0;
      hold_id_ex_o  = 1'b0;
      hold_ex_mem_o = 1'b0;
      pc_set_o      = 1'b0;
      pc_set_val_o  = '0;
      irq_ack_o     = 1'b0;
      w_next_state  = r_state;
      w_next_drain  = r_drain_cnt;
      w_epc_load    = 1'b0;
      if (!rst) begin
         if (mem_busy_i) begin
            hold_pc_o     = 1'b1;
            hold_if_id_o  = 1'b1;
            hold_id_ex_o  = 1'b1;
            hold_ex_mem_o = 1'b1;
         end else begin
            case (r_state)
               c_st_run: begin
                  if (br_taken_i) begin
                     pc_set_o      = 1'b1;
                     pc_set_val_o  = br_target_i;
                     flush_if_id_o = 1'b1;
                     flush_id_ex_o = 1'b1;
                     w_next_state  = c_st_redirect;
                  end else if (irq_i) begin
                     hold_pc_o     = 1'b1;
                     hold_if_id_o  = 1'b1;
                     flush_id_ex_o = 1'b1;
                     w_epc_load    = 1'b1;
                     w_next_drain  = c_drain_load;
                     w_next_state  = c_st_irq_drain;
                  end else if (ld_use_i) begin
                     hold_pc_o     = 1'b1;
                     hold_if_id_o  = 1'b1;
                     flush_id_ex_o = 1'b1;
                  end
               end
               c_st_redirect: begin
                  // Kill the instruction fetched from the stale PC.
                  flush_if_id_o = 1'b1;
                  w_next_state  = c_st_run;
               end
               c_st_irq_drain: begin
                  hold_pc_o     = 1'b1;
                  hold_if_id_o  = 1'b1;
                  flush_id_ex_o = 1'b1;
                  if (r_drain_cnt == '0) begin
                     w_next_state = c_st_irq_jump;
                  end else begin
                     w_next_drain = r_drain_cnt - DRAIN_W'(1);
                  end
               end
               c_st_irq_jump: begin
                  pc_set_o      = 1'b1;
                  pc_set_val_o  = irq_vec_i;
                  irq_ack_o     = 1'b1;
                  flush_if_id_o = 1'b1;
                  flush_id_ex_o = 1'b1;
                  w_next_state  = c_st_redirect;
               end
               default: begin
                  w_next_state = c_st_run;
               end
            endcase
         end
      end
   end

   // Sequencer state, drain counter and captured return address.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= c_st_run;
         r_drain_cnt <= '0;
         r_epc       <= '0;
      end else begin
         r_state     <= w_next_state;
         r_drain_cnt <= w_next_drain;
         if (w_epc_load) begin
            r_epc <= id_pc_i;
         end
      end
   end

`ifdef PIPE_CTRL_MEM_TIMEOUT_EN
   localparam int TO_W = $clog2(MEM_TIMEOUT + 1);
   localparam logic [TO_W-1:0] c_to_max  = TO_W'(MEM_TIMEOUT);
   localparam logic [TO_W-1:0] c_to_last = TO_W'(MEM_TIMEOUT - 1);

   logic [TO_W-1:0] r_busy_cnt;

   // Count consecutive busy cycles, saturating so the error pulses only once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_busy_cnt <= '0;
      end else if (!mem_busy_i) begin
         r_busy_cnt <= '0;
      end else if (r_busy_cnt != c_to_max) begin
         r_busy_cnt <= r_busy_cnt + TO_W'(1);
      end
   end

   assign bus_err_o = !rst && mem_busy_i && (r_busy_cnt == c_to_last);
`else
   assign bus_err_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central stall/flush scheduler for the 5-stage core.
- Drives the hold/flush inputs of the if_id, id_ex and ex_mem pipeline registers and the PC redirect port, from hazard, branch, memory-wait and interrupt events.
- Sequences a multi-cycle interrupt entry: drain, redirect, extra fetch-bubble.
- Sits beside the pipeline registers; the PC generator and the pipeline registers consume its outputs the same cycle.

Parameters:
- DATA_WIDTH, 32, width of PC/address values.
- DRAIN_CYCLES, 2, bubble cycles inserted before an interrupt redirect so EX/MEM instructions retire.
- MEM_TIMEOUT, 16, consecutive mem_busy_i cycles before bus_err_o (only with the optional feature).

Ports:
- clk  in  1  core clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_busy_i  in  1  data bus not ready; whole pipeline must freeze.
- br_taken_i  in  1  branch/jump in EX resolved taken.
- br_target_i  in  DATA_WIDTH  redirect target for br_taken_i.
- ld_use_i  in  1  instruction in ID reads rd of a load in EX.
- irq_i  in  1  level interrupt request.
- irq_vec_i  in  DATA_WIDTH  interrupt handler address.
- id_pc_i  in  DATA_WIDTH  PC of instruction currently in ID.
- hold_pc_o  out  1  PC generator keeps current PC.
- hold_if_id_o  out  1  if_id hold.
- flush_if_id_o  out  1  if_id flush (bubble).
- flush_id_ex_o  out  1  id_ex flush (bubble).
- hold_id_ex_o  out  1  id_ex hold.
- hold_ex_mem_o  out  1  ex_mem hold.
- pc_set_o  out  1  load PC with pc_set_val_o next edge.
- pc_set_val_o  out  DATA_WIDTH  redirect address.
- epc_o  out  DATA_WIDTH  registered return address of last taken interrupt.
- irq_ack_o  out  1  one-cycle pulse when the interrupt redirect is issued.
- bus_err_o  out  1  memory-wait timeout pulse.

Behaviour:
- Control outputs are combinational from state and inputs; state, drain_cnt and epc_o are registered.
- States: RUN, REDIRECT, IRQ_DRAIN, IRQ_JUMP.
- Reset (rst=1, async):
  - state=RUN, drain_cnt=0, epc_o=0.
  - All 1-bit outputs are 0 and pc_set_val_o=0 while rst is high.
  - A reset mid-sequence abandons it; no irq_ack_o is issued.
- Freeze (highest priority, any state): mem_busy_i=1 drives all hold_* =1.
  - All flush_* =0, pc_set_o=0, irq_ack_o=0.
  - State, drain_cnt and epc_o do not change.
- RUN, priority br_taken_i > irq_i > ld_use_i:
  - br_taken_i: pc_set_o=1, pc_set_val_o=br_target_i, flush_if_id_o=1, flush_id_ex_o=1; next REDIRECT.
  - irq_i: epc_o<=id_pc_i, flush_id_ex_o=1, hold_pc_o=1, hold_if_id_o=1, drain_cnt<=DRAIN_CYCLES-1; next IRQ_DRAIN.
  - ld_use_i: hold_pc_o=1, hold_if_id_o=1, flush_id_ex_o=1 for that cycle only; stay RUN.
  - Otherwise all outputs 0.
- REDIRECT: flush_if_id_o=1, which discards the instruction fetched from the stale PC. Next RUN.
  - irq_i, ld_use_i and br_taken_i are ignored in this state. EX holds a bubble, so br_taken_i cannot legally assert.
- IRQ_DRAIN: hold_pc_o=1, hold_if_id_o=1, flush_id_ex_o=1.
  - If drain_cnt==0, next IRQ_JUMP; else decrement drain_cnt.
  - br_taken_i and ld_use_i are ignored.
- IRQ_JUMP: pc_set_o=1, pc_set_val_o=irq_vec_i, irq_ack_o=1, flush_if_id_o=1, flush_id_ex_o=1. Next REDIRECT.
- Interrupt entry latency with no mem stall: 1+DRAIN_CYCLES cycles from entry to the irq_ack_o cycle.
- irq_i dropping after entry does not abort the sequence.
- hold_* and flush_* to the same register are never both 1.
- DRAIN_CYCLES must be at least 1.

Optional Feature:
- Macro: PIPE_CTRL_MEM_TIMEOUT_EN.
- Enabled:
  - A $clog2(MEM_TIMEOUT+1)-bit counter increments on each mem_busy_i=1 cycle, saturating at MEM_TIMEOUT.
  - It clears on mem_busy_i=0 or rst.
  - bus_err_o=1 for exactly the one cycle in which the counter steps from MEM_TIMEOUT-1 to MEM_TIMEOUT.
  - The freeze continues regardless of bus_err_o.
- Disabled: no counter is built; bus_err_o is tied 0.

Test Plan:
- ld_use_i=1 for 1 cycle in RUN -> that cycle hold_pc_o=hold_if_id_o=flush_id_ex_o=1; next cycle all 0; state stays RUN.
- br_taken_i=1, br_target_i=0x0000_0100 -> cycle0 pc_set_o=1 with pc_set_val_o=0x100 and both flushes 1; cycle1 flush_if_id_o=1 only; cycle2 all 0.
- irq_i=1, id_pc_i=0x0000_0040, irq_vec_i=0x0000_0800, DRAIN_CYCLES=2 -> entry cycle flush/hold; 2 drain cycles; 4th cycle pc_set_val_o=0x800 with irq_ack_o=1; epc_o=0x40; 5th cycle REDIRECT flush.
- br_taken_i and irq_i asserted the same cycle in RUN -> branch redirect wins; irq is taken once RUN is re-entered, with epc_o = the ID PC at that time.
- mem_busy_i=1 for 3 cycles during IRQ_DRAIN -> all holds 1, no flushes, drain_cnt frozen; the sequence resumes and irq_ack_o fires 3 cycles later than without the stall.
- With PIPE_CTRL_MEM_TIMEOUT_EN, MEM_TIMEOUT=16, mem_busy_i=1 for 20 cycles -> bus_err_o pulses once on the 16th busy cycle. Assert rst mid-sequence -> all outputs 0 immediately, state RUN.
